// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// The payload struct is sized for the widest supported operand (64 bits).
// Narrower instances keep their data in the low WIDTH bits, and the upper
// bits stay zero.
package shifter_pkg;

  localparam int MAX_WIDTH   = 64;
  localparam int MAX_SHAMT_W = 6;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef struct packed {
    logic [MAX_WIDTH-1:0]   data;   // operand window in bits [WIDTH-1:0]
    logic [MAX_SHAMT_W-1:0] shamt;  // remaining shift bits, LSB = this stage
    logic                   dir;    // DIR_LEFT / DIR_RIGHT
    logic                   arith;  // sign-fill on right shift
    logic                   rot;    // rotate instead of shift
    logic                   sign;   // operand MSB captured at input
  } payload_t;

  // Ones in the low 'width' bits of the payload data field.
  function automatic logic [MAX_WIDTH-1:0] width_mask(input int width);
    width_mask = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational barrel-shifter stage: shifts by DIST when the LSB of the
// remaining shift amount is set, and otherwise passes the payload through.
// The shift amount leaves the stage shifted down one bit for the next stage.
// When SHIFTER_ROTATE_EN is defined, a set rot field turns the shift into a
// rotate within the WIDTH window.
import shifter_pkg::*;

module shift_stage #(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  payload_t din,
  output payload_t dout
);

  localparam logic [MAX_WIDTH-1:0] MASK = width_mask(WIDTH);
  // Top DIST bits of the window, which sign fill sets on a right shift.
  localparam logic [MAX_WIDTH-1:0] FILL = MASK & ~(MASK >> DIST);

  logic [MAX_WIDTH-1:0] shifted;

  // Select the shifted or the unshifted data and retire one shamt bit.
  always_comb begin
    shifted    = din.data;
    dout       = din;
    dout.shamt = din.shamt >> 1;
    if (din.shamt[0]) begin
      if (din.dir == DIR_LEFT) begin
        shifted = (din.data << DIST) & MASK;
      end else begin
        // Fill uses the captured sign, not the current MSB of the window.
        shifted = (din.data >> DIST) | ((din.arith && din.sign) ? FILL : '0);
      end
`ifdef SHIFTER_ROTATE_EN
      if (din.rot) begin
        if (din.dir == DIR_LEFT) begin
          shifted = ((din.data << DIST) | (din.data >> (WIDTH - DIST))) & MASK;
        end else begin
          shifted = ((din.data >> DIST) | (din.data << (WIDTH - DIST))) & MASK;
        end
      end
`endif
      dout.data = shifted;
    end
  end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter with SHAMT_W register stages. Stage k shifts by 2^k.
// Optional feature macro: SHIFTER_ROTATE_EN adds the rot port and rotate logic.
//
// Handshake: a word moves on a rising edge where valid and ready are both 1,
// on the input and on the output. The whole pipeline stalls together when the
// output holds a result that the consumer does not take. Bubbles never
// collapse, so in_ready = !(out_valid && !out_ready).
import shifter_pkg::*;

module pipe_barrel_shifter #(
  parameter int WIDTH = 32,  // power of two, 8..64
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir,
  input  logic               arith,
`ifdef SHIFTER_ROTATE_EN
  input  logic               rot,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   b
);

  payload_t             in_p;
  payload_t             stage_in  [SHAMT_W];
  payload_t             stage_out [SHAMT_W];
  payload_t             pipe_q    [SHAMT_W];
  logic [SHAMT_W-1:0]   valid_q;
  logic                 stall;

  assign stall     = valid_q[SHAMT_W-1] && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = valid_q[SHAMT_W-1];
  assign b         = pipe_q[SHAMT_W-1].data[WIDTH-1:0];

  // Pack the operand and its controls into the stage payload.
  always_comb begin
    in_p                     = '0;
    in_p.data[WIDTH-1:0]     = a;
    in_p.shamt[SHAMT_W-1:0]  = shamt;
    in_p.dir                 = dir;
    in_p.arith               = arith;
`ifdef SHIFTER_ROTATE_EN
    in_p.rot                 = rot;
`else
    in_p.rot                 = 1'b0;
`endif
    in_p.sign                = a[WIDTH-1];
  end

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign stage_in[k] = in_p;
    end else begin : g_rest
      assign stage_in[k] = pipe_q[k-1];
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_stage (
      .din  (stage_in[k]),
      .dout (stage_out[k])
    );
  end

  // Advance every stage together unless the output is stalled. Payloads load
  // only behind a valid word, so b keeps its last result through bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < SHAMT_W; k++) begin
        pipe_q[k] <= '0;
      end
    end else if (!stall) begin
      valid_q <= {valid_q[SHAMT_W-2:0], in_valid};
      if (in_valid) begin
        pipe_q[0] <= stage_out[0];
      end
      for (int k = 1; k < SHAMT_W; k++) begin
        if (valid_q[k-1]) begin
          pipe_q[k] <= stage_out[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Bench for pipe_barrel_shifter at WIDTH=32. The drivers push expected results.
// A negedge monitor pops them and compares whenever an output handshake occurs.
module tb_pipe_barrel_shifter;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int LAT     = 5;

  typedef struct {
    logic [WIDTH-1:0] a;
    int               s;
    logic             d;
    logic             ar;
    logic             r;
    logic [WIDTH-1:0] e;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [SHAMT_W-1:0] shamt;
  logic               dir;
  logic               arith;
  logic               rot;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   b;

  int errors = 0;
  int checks = 0;
  int cnt    = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               lat_q[$];
  logic             tog_en  = 1'b0;
  logic             chk_rdy = 1'b0;
  logic [WIDTH-1:0] mon_e;
  int               mon_l;

  vec_t dir_tab[$];
  vec_t tog_tab[$];

  pipe_barrel_shifter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .shamt     (shamt),
    .dir       (dir),
    .arith     (arith),
`ifdef SHIFTER_ROTATE_EN
    .rot       (rot),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .b         (b)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Consumer: out_ready is held high, or toggled every cycle when tog_en is set.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) out_ready = !out_ready;
      else        out_ready = 1'b1;
    end
  end

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Call just after a rising edge. The task returns just after the edge that
  // accepted the operand.
  task automatic send(input vec_t v, input bit track, input bit lat);
    int  tries = 0;
    bit  done  = 0;
    a        = v.a;
    shamt    = v.s[SHAMT_W-1:0];
    dir      = v.d;
    arith    = v.ar;
    rot      = v.r;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1;
        if (track) begin
          exp_q.push_back(v.e);
          lat_q.push_back(lat ? cnt : -1);
        end
      end else if (++tries > 100) begin
        done = 1;
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_ready stayed %b expected 1", in_ready);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d results pending expected 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (chk_rdy)
        check_int("in_ready_rule", int'(in_ready), int'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got b=%h expected no result", b);
        end else begin
          mon_e = exp_q.pop_front();
          mon_l = lat_q.pop_front();
          check("result", b, mon_e);
          if (mon_l >= 0) check_int("latency", cnt - mon_l, LAT);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Directed vectors: a, shamt, dir, arith, rot, expected.
    dir_tab.push_back('{32'h8000_00F0, 4,  1'b1, 1'b1, 1'b0, 32'hF800_000F});
    dir_tab.push_back('{32'h8000_00F0, 4,  1'b1, 1'b0, 1'b0, 32'h0800_000F});
    dir_tab.push_back('{32'h8000_00F0, 4,  1'b0, 1'b0, 1'b0, 32'h0000_0F00});
    dir_tab.push_back('{32'h8000_00F0, 4,  1'b0, 1'b1, 1'b0, 32'h0000_0F00});
    dir_tab.push_back('{32'h8000_0001, 31, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF});
    dir_tab.push_back('{32'h8000_0001, 31, 1'b1, 1'b0, 1'b0, 32'h0000_0001});
    dir_tab.push_back('{32'h8000_0001, 31, 1'b0, 1'b0, 1'b0, 32'h8000_0000});
    dir_tab.push_back('{32'h7FFF_FFFF, 3,  1'b1, 1'b1, 1'b0, 32'h0FFF_FFFF});
    dir_tab.push_back('{32'h4000_0000, 1,  1'b1, 1'b1, 1'b0, 32'h2000_0000});
    dir_tab.push_back('{32'h8000_0001, 0,  1'b0, 1'b0, 1'b0, 32'h8000_0001});
    dir_tab.push_back('{32'h8000_0001, 0,  1'b1, 1'b0, 1'b0, 32'h8000_0001});
    dir_tab.push_back('{32'h8000_0001, 0,  1'b1, 1'b1, 1'b0, 32'h8000_0001});

    tog_tab.push_back('{32'h0000_00A5, 0,  1'b0, 1'b0, 1'b0, 32'h0000_00A5});
    tog_tab.push_back('{32'h0000_00A5, 1,  1'b0, 1'b0, 1'b0, 32'h0000_014A});
    tog_tab.push_back('{32'h0000_00A5, 2,  1'b0, 1'b0, 1'b0, 32'h0000_0294});
    tog_tab.push_back('{32'h0000_00A5, 3,  1'b0, 1'b0, 1'b0, 32'h0000_0528});
    tog_tab.push_back('{32'h0000_00A5, 4,  1'b0, 1'b0, 1'b0, 32'h0000_0A50});
    tog_tab.push_back('{32'hF000_0000, 1,  1'b1, 1'b1, 1'b0, 32'hF800_0000});
    tog_tab.push_back('{32'hF000_0000, 2,  1'b1, 1'b1, 1'b0, 32'hFC00_0000});
    tog_tab.push_back('{32'hF000_0000, 3,  1'b1, 1'b0, 1'b0, 32'h1E00_0000});
    tog_tab.push_back('{32'h0000_000F, 28, 1'b0, 1'b0, 1'b0, 32'hF000_0000});
    tog_tab.push_back('{32'h8001_0000, 16, 1'b1, 1'b1, 1'b0, 32'hFFFF_8001});

    rst = 1'b1; in_valid = 1'b0; a = '0; shamt = '0; dir = 1'b0; arith = 1'b0; rot = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check_int("reset_out_valid", int'(out_valid), 0);
    check_int("reset_in_ready", int'(in_ready), 1);
    check("reset_b", b, '0);
    @(posedge clk); #1;

    // Directed vectors back to back. The first one also checks latency.
    foreach (dir_tab[i]) send(dir_tab[i], 1'b1, i == 0);
    drain();

    // b holds the last result while the output is idle.
    repeat (3) @(negedge clk);
    check_int("idle_out_valid", int'(out_valid), 0);
    check("idle_b_hold", b, 32'h8000_0001);
    @(posedge clk); #1;

    // Ten back-to-back operations while out_ready toggles every cycle.
    tog_en  = 1'b1;
    chk_rdy = 1'b1;
    foreach (tog_tab[i]) send(tog_tab[i], 1'b1, 1'b0);
    drain();
    chk_rdy = 1'b0;
    tog_en  = 1'b0;

`ifdef SHIFTER_ROTATE_EN
    send('{32'h1234_5678, 8, 1'b0, 1'b0, 1'b1, 32'h3456_7812}, 1'b1, 1'b0);
    send('{32'h1234_5678, 8, 1'b1, 1'b0, 1'b1, 32'h7812_3456}, 1'b1, 1'b0);
    send('{32'h1234_5678, 8, 1'b1, 1'b1, 1'b1, 32'h7812_3456}, 1'b1, 1'b0);
    send('{32'h8000_0001, 0, 1'b1, 1'b0, 1'b1, 32'h8000_0001}, 1'b1, 1'b0);
    drain();
`endif

    // Reset with three operations in flight. None of them may appear.
    send(dir_tab[0], 1'b0, 1'b0);
    send(dir_tab[1], 1'b0, 1'b0);
    send(dir_tab[2], 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_int("post_reset_in_ready", int'(in_ready), 1);
    check_int("post_reset_out_valid", int'(out_valid), 0);
    check("post_reset_b", b, '0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_int("post_reset_quiet", int'(out_valid), 0);
    end
    @(posedge clk); #1;
    send(dir_tab[0], 1'b1, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_barrel_shifter.md
PIPE_BARREL_SHIFTER -- requirements
Module: pipe_barrel_shifter

Interface
REQ-001 Parameter: WIDTH, default 32, data width; SHALL be a power of two, 8..64.
REQ-002 Derived localparam: SHAMT_W, equal to log2(WIDTH) (5 at default), shift-amount width and pipeline depth.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand presented.
REQ-006 in_ready  output  1  block accepts the operand this cycle.
REQ-007 a  input  WIDTH  operand.
REQ-008 shamt  input  SHAMT_W  shift amount.
REQ-009 dir  input  1  0 = left, 1 = right.
REQ-010 arith  input  1  right shift only: 1 = sign-fill, 0 = zero-fill; ignored when dir=0.
REQ-011 rot  input  1  rotate select; present only with SHIFTER_ROTATE_EN.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 b  output  WIDTH  result.

Function
REQ-015 Transfer occurs on a rising edge where valid and ready are both 1, on input and on output.
REQ-016 Pipeline: SHAMT_W register stages; stage k shifts by 2^k when captured shamt bit k=1, else passes data through.
REQ-017 Each stage carries data, valid, remaining shamt bits, dir, arith, rot, and the sign bit a[WIDTH-1] captured at input.
REQ-018 Right arithmetic fill uses the captured sign bit, never the intermediate MSB.
REQ-019 Latency: exactly SHAMT_W cycles from input handshake to out_valid with no stall; throughput one operation per cycle.
REQ-020 Stall: when out_valid=1 and out_ready=0, every stage holds; in_ready = !(out_valid && !out_ready).
REQ-021 Bubbles: an empty stage SHALL be filled while a later stage is held only when the occupancy rule of REQ-020 allows; no bubble collapsing. (Global stall only.)
REQ-022 shamt=0: b equals a for every mode.
REQ-023 Left shift: zero-fill LSBs; logical right: zero-fill MSBs.
REQ-024 b, when out_valid=0, holds its last value; consumers ignore it.
REQ-025 Results leave in input order; no reordering or dropping under any pattern of out_ready.
REQ-026 Simultaneous accept and emit in the same cycle is legal and loses no data.

Reset
REQ-027 rst=1 clears all stage valid bits; out_valid=0 in the following cycle.
REQ-028 rst clears b and all stage data to 0.
REQ-029 Reset mid-operation discards every in-flight operation; in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-030 Macro SHIFTER_ROTATE_EN defined: port rot exists; rot=1 rotates in direction dir, arith ignored; rot=0 behaves as REQ-023/018.
REQ-031 SHIFTER_ROTATE_EN undefined: no rot port, no rotate logic; behaviour identical to rot=0.

Structure
REQ-032 Shared package shifter_pkg: direction encoding constants (DIR_LEFT=0, DIR_RIGHT=1) and a stage-payload struct typedef (data, shamt, dir, arith, rot, sign).
REQ-033 One sub-module, shift_stage, parametrised by WIDTH and stage distance DIST: combinational shift by DIST under enable, selectable direction, fill, and rotate; instantiated SHAMT_W times by generate, followed by a register.

Verification (WIDTH=32, latency 5)
REQ-034 a=0x8000_00F0, shamt=4, dir=1, arith=1 -> b=0xF800_000F, out_valid exactly 5 cycles after accept.
REQ-035 a=0x8000_00F0, shamt=4, dir=1, arith=0 -> b=0x0800_000F; dir=0 -> b=0x0000_0F00.
REQ-036 a=0x8000_0001, shamt=31, dir=1, arith=1 -> 0xFFFF_FFFF; shamt=0 for every mode -> 0x8000_0001.
REQ-037 Ten back-to-back ops, out_ready toggling 1/0 every cycle -> ten results in order, none lost or duplicated; in_ready low exactly when out_valid=1 and out_ready=0.
REQ-038 rst asserted with 3 ops in flight -> no out_valid after reset, in_ready=1 in the first cycle after deassertion, next op correct.
REQ-039 With SHIFTER_ROTATE_EN: a=0x1234_5678, shamt=8, rot=1, dir=0 -> 0x3456_7812; dir=1 -> 0x7812_3456.
